// File: rtl/seven_seg_capture.sv
// seven_seg_capture: reconstructs four hex digits from a multiplexed,
// active-low seven-segment display bus. Each position must show the same
// 8-bit pattern (segments plus decimal point) for STABLE_COUNT selecting
// samples before it is committed. A position that goes unselected for
// TIMEOUT cycles loses its valid flag.
module seven_seg_capture #(
  parameter int STABLE_COUNT = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anodes,
  input  logic [7:0]  segments,
  output logic [15:0] digits,
  output logic [3:0]  decimal_points,
  output logic [3:0]  digit_valid,
  output logic [3:0]  pattern_error,
  output logic        update
);

  localparam logic [3:0]  STABLE_C = 4'(STABLE_COUNT);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  // Pattern decode: {legal, blank, value[3:0]} for an active-low gfedcba pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] pat);
    logic [5:0] r;
    case (pat)
      7'b1000000: r = {2'b10, 4'h0};
      7'b1111001: r = {2'b10, 4'h1};
      7'b0100100: r = {2'b10, 4'h2};
      7'b0110000: r = {2'b10, 4'h3};
      7'b0011001: r = {2'b10, 4'h4};
      7'b0010010: r = {2'b10, 4'h5};
      7'b0000010: r = {2'b10, 4'h6};
      7'b1111000: r = {2'b10, 4'h7};
      7'b0000000: r = {2'b10, 4'h8};
      7'b0010000: r = {2'b10, 4'h9};
      7'b0001000: r = {2'b10, 4'hA};
      7'b0000011: r = {2'b10, 4'hB};
      7'b1000110: r = {2'b10, 4'hC};
      7'b0100001: r = {2'b10, 4'hD};
      7'b0000110: r = {2'b10, 4'hE};
      7'b0001110: r = {2'b10, 4'hF};
      7'b1111111: r = {2'b01, 4'h0};
      default:    r = {2'b00, 4'h0};
    endcase
    return r;
  endfunction

  // ---------------- stage 1: input capture ----------------
  logic [3:0] anodes_p1_q;
  logic [7:0] seg_p1_q;

  // Register the raw display bus once before any use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anodes_p1_q <= '1;
      seg_p1_q    <= '1;
    end else begin
      anodes_p1_q <= anodes;
      seg_p1_q    <= segments;
    end
  end

  logic [3:0] sel;
  logic [1:0] sel_idx;

  // Only a single cleared anode selects a position; anything else is ignored.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    case (anodes_p1_q)
      4'b1110: begin sel = 4'b0001; sel_idx = 2'd0; end
      4'b1101: begin sel = 4'b0010; sel_idx = 2'd1; end
      4'b1011: begin sel = 4'b0100; sel_idx = 2'd2; end
      4'b0111: begin sel = 4'b1000; sel_idx = 2'd3; end
      default: ;
    endcase
  end

  // ---------------- stage 2: match tracking and commit detect ----------------
  logic [7:0]  cand_q  [4];
  logic [7:0]  cand_d  [4];
  logic [3:0]  match_q [4];
  logic [3:0]  match_d [4];
  logic [15:0] sil_q   [4];
  logic [15:0] sil_d   [4];
  logic [3:0]  tmo;
  logic        commit_d;

  // Candidate/match/silence next state; a commit fires only on the sample
  // that first brings the match count to STABLE_COUNT.
  always_comb begin
    commit_d = 1'b0;
    tmo      = '0;
    for (int i = 0; i < 4; i++) begin
      cand_d[i]  = cand_q[i];
      match_d[i] = match_q[i];
      sil_d[i]   = sil_q[i];
      if (sel[i]) begin
        sil_d[i] = '0;
        if (seg_p1_q == cand_q[i]) begin
          if (match_q[i] < STABLE_C) begin
            match_d[i] = match_q[i] + 4'd1;
            commit_d   = (match_q[i] == STABLE_C - 4'd1);
          end
        end else begin
          cand_d[i]  = seg_p1_q;
          match_d[i] = 4'd1;
          commit_d   = (STABLE_C == 4'd1);
        end
      end else begin
        if (sil_q[i] != 16'hFFFF) sil_d[i] = sil_q[i] + 16'd1;
        // The silence counter reaches TIMEOUT on this edge.
        if (sil_q[i] == TMO_LAST) begin
          tmo[i]     = 1'b1;
          match_d[i] = '0;
        end
      end
    end
  end

  logic       commit_p2_q;
  logic [1:0] pos_p2_q;
  logic [7:0] seg_p2_q;

  // Per-position tracking state and the commit request for the output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cand_q[i]  <= 8'hFF;
        match_q[i] <= '0;
        sil_q[i]   <= '0;
      end
      commit_p2_q <= 1'b0;
      pos_p2_q    <= '0;
      seg_p2_q    <= '1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cand_q[i]  <= cand_d[i];
        match_q[i] <= match_d[i];
        sil_q[i]   <= sil_d[i];
      end
      commit_p2_q <= commit_d;
      pos_p2_q    <= sel_idx;
      seg_p2_q    <= seg_p1_q;
    end
  end

  // ---------------- stage 3: committed outputs ----------------
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  err_q, err_d;
  logic        update_q, update_d;
  logic [5:0]  dec;

  // Apply the pending commit (which wins over a timeout on the same position),
  // then clear valid on timed-out positions; update flags any visible change.
  // The decimal point follows the sampled level on every commit.
  always_comb begin
    dec      = decode_seg(seg_p2_q[6:0]);
    digits_d = digits_q;
    dp_d     = dp_q;
    valid_d  = valid_q;
    err_d    = err_q;
    for (int i = 0; i < 4; i++) begin
      if (commit_p2_q && (pos_p2_q == 2'(i))) begin
        dp_d[i] = seg_p2_q[7];
        if (dec[5]) begin
          digits_d[4*i +: 4] = dec[3:0];
          valid_d[i]         = 1'b1;
          err_d[i]           = 1'b0;
        end else if (dec[4]) begin
          valid_d[i] = 1'b0;
          err_d[i]   = 1'b0;
        end else begin
          valid_d[i] = 1'b0;
          err_d[i]   = 1'b1;
        end
      end else if (tmo[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    update_d = ({digits_d, dp_d, valid_d, err_d} != {digits_q, dp_q, valid_q, err_q});
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      dp_q     <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      update_q <= 1'b0;
    end else begin
      digits_q <= digits_d;
      dp_q     <= dp_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      update_q <= update_d;
    end
  end

  assign digits         = digits_q;
  assign decimal_points = dp_q;
  assign digit_valid    = valid_q;
  assign pattern_error  = err_q;
  assign update         = update_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: directed display-bus stimulus, a
// sample-history model of the expected outputs compared every cycle, and
// hand-computed literal checks at key points.
module tb_seven_seg_capture;
  localparam int STABLE = 4;
  localparam int TMO    = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  anodes = 4'hF;
  logic [7:0]  segments = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  decimal_points, digit_valid, pattern_error;
  logic        update;

  seven_seg_capture #(.STABLE_COUNT(STABLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .anodes(anodes), .segments(segments),
    .digits(digits), .decimal_points(decimal_points), .digit_valid(digit_valid),
    .pattern_error(pattern_error), .update(update)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [7:0] m_cand [4];
  int         m_run  [4];
  int         m_last [4];   // edge index of the last selecting sample
  int         m_rel;        // edges since reset release
  logic       pa_v, pb_v;
  int         pa_pos, pb_pos;
  logic [7:0] pa_seg, pb_seg;
  logic [3:0] e_dig [4];
  logic [3:0] e_dp, e_val, e_err;
  logic       e_upd;

  function automatic int lookup(input logic [6:0] p);
    if (p == 7'h7F) return -2;
    for (int k = 0; k < 16; k++) if (hex_tab[k] == p) return k;
    return -1;
  endfunction

  function automatic int sel_pos(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [27:0] pack_exp();
    return {e_dig[3], e_dig[2], e_dig[1], e_dig[0], e_dp, e_val, e_err};
  endfunction

  always @(posedge clk or posedge reset) begin : mdl
    logic [27:0] old_v;
    int p, k;
    if (reset) begin
      for (int q = 0; q < 4; q++) begin
        m_cand[q] = 8'hFF; m_run[q] = 0; m_last[q] = -1; e_dig[q] = 4'h0;
      end
      e_dp = 4'h0; e_val = 4'h0; e_err = 4'h0; e_upd = 1'b0;
      m_rel = 0; pa_v = 1'b0; pb_v = 1'b0;
    end else begin
      m_rel++;
      old_v = pack_exp();
      // a sample seen two edges ago that completed a stable run shows now
      if (pb_v) begin
        k = lookup(pb_seg[6:0]);
        e_dp[pb_pos] = pb_seg[7];
        if (k >= 0) begin
          e_dig[pb_pos] = k[3:0]; e_val[pb_pos] = 1'b1; e_err[pb_pos] = 1'b0;
        end else if (k == -2) begin
          e_val[pb_pos] = 1'b0; e_err[pb_pos] = 1'b0;
        end else begin
          e_val[pb_pos] = 1'b0; e_err[pb_pos] = 1'b1;
        end
      end
      for (int q = 0; q < 4; q++)
        if (m_rel == m_last[q] + 1 + TMO && !(pb_v && pb_pos == q)) e_val[q] = 1'b0;
      e_upd = (pack_exp() != old_v);
      pb_v = pa_v; pb_pos = pa_pos; pb_seg = pa_seg; pa_v = 1'b0;
      p = sel_pos(anodes);
      if (p >= 0) begin
        if (m_rel - m_last[p] > TMO) m_run[p] = 0;
        if (segments == m_cand[p]) m_run[p]++;
        else begin m_cand[p] = segments; m_run[p] = 1; end
        if (m_run[p] == STABLE) begin pa_v = 1'b1; pa_pos = p; pa_seg = segments; end
        m_last[p] = m_rel;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("digits", 32'(digits), 32'({e_dig[3], e_dig[2], e_dig[1], e_dig[0]}));
    chk("decimal_points", 32'(decimal_points), 32'(e_dp));
    chk("digit_valid", 32'(digit_valid), 32'(e_val));
    chk("pattern_error", 32'(pattern_error), 32'(e_err));
    chk("update", 32'(update), 32'(e_upd));
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] a, input logic [7:0] s);
    anodes = a; segments = s;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'hF, 8'hFF);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_err", 32'(pattern_error), 32'h0);
    chk("rst_dp", 32'(decimal_points), 32'h0);
    chk("rst_update", 32'(update), 32'h0);
    reset = 1'b0;

    // digit 2 on position 0
    repeat (4) step(4'b1110, 8'b0010_0100);
    idle(1);
    chk("t1_valid_early", 32'(digit_valid[0]), 32'h0);
    chk("t1_update_early", 32'(update), 32'h0);
    idle(1);
    chk("t1_digit", 32'(digits[3:0]), 32'h2);
    chk("t1_valid", 32'(digit_valid[0]), 32'h1);
    chk("t1_update", 32'(update), 32'h1);
    idle(1);
    chk("t1_update_once", 32'(update), 32'h0);

    // 9,9,9 then five 8s on position 2: commit at the 4th 8
    repeat (3) step(4'b1011, 8'b0001_0000);
    repeat (4) step(4'b1011, 8'b0000_0000);
    step(4'b1011, 8'b0000_0000);
    chk("t2_valid_early", 32'(digit_valid[2]), 32'h0);
    idle(1);
    chk("t2_digit", 32'(digits[11:8]), 32'h8);
    chk("t2_valid", 32'(digit_valid[2]), 32'h1);
    chk("t2_update", 32'(update), 32'h1);
    idle(1);
    chk("t2_no_recommit", 32'(update), 32'h0);

    // non-selecting anode values with random segments
    for (int i = 0; i < 20; i++) step((i % 2) ? 4'b1100 : 4'b1111, 8'($urandom));
    chk("t3_digits", 32'(digits), 32'h0802);
    chk("t3_valid", 32'(digit_valid), 32'h5);
    chk("t3_err", 32'(pattern_error), 32'h0);

    // illegal pattern on position 1
    repeat (4) step(4'b1101, 8'b0101_0101);
    idle(2);
    chk("t4_err", 32'(pattern_error[1]), 32'h1);
    chk("t4_valid", 32'(digit_valid[1]), 32'h0);
    chk("t4_digit", 32'(digits[7:4]), 32'h0);
    chk("t4_update", 32'(update), 32'h1);

    // blank with decimal point high on position 1
    repeat (4) step(4'b1101, 8'hFF);
    idle(2);
    chk("t5_err", 32'(pattern_error[1]), 32'h0);
    chk("t5_valid", 32'(digit_valid[1]), 32'h0);
    chk("t5_dp", 32'(decimal_points[1]), 32'h1);

    // F on position 3, then silence until timeout
    repeat (4) step(4'b0111, 8'b0000_1110);
    idle(2);
    chk("t6_digit", 32'(digits[15:12]), 32'hF);
    chk("t6_valid", 32'(digit_valid[3]), 32'h1);
    idle(1022);
    chk("t6_valid_before_tmo", 32'(digit_valid[3]), 32'h1);
    idle(1);
    chk("t6_valid_tmo", 32'(digit_valid[3]), 32'h0);
    chk("t6_digit_kept", 32'(digits[15:12]), 32'hF);
    chk("t6_update", 32'(update), 32'h1);
    idle(1);
    chk("t6_update_once", 32'(update), 32'h0);

    // reset mid-accumulation discards partial matches
    repeat (2) step(4'b1110, 8'b0001_0010);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    repeat (2) step(4'b1110, 8'b0001_0010);
    idle(4);
    chk("t7_digits", 32'(digits), 32'h0);
    chk("t7_dp", 32'(decimal_points), 32'h0);
    chk("t7_valid", 32'(digit_valid), 32'h0);
    chk("t7_err", 32'(pattern_error), 32'h0);
    chk("t7_update", 32'(update), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter STABLE_COUNT, default 4, gives the consecutive identical samples of one digit position required before commit (range 1..15).
REQ-002 Parameter TIMEOUT, default 1024, gives the clock cycles without selection of a position after which that position is invalidated (range 2..65535).
REQ-003 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, is the asynchronous active-high reset.
REQ-005 Port anodes, input, 4, is the active-low digit select observed from a multiplexed display bus.
REQ-006 Port segments, input, 8, carries bits[6:0] as an active-low gfedcba pattern and bit[7] as the decimal point taken as its sampled level.
REQ-007 Port digits, output, 16, holds the reconstructed hex values, with position i in bits[4i+3:4i].
REQ-008 Port decimal_points, output, 4, holds the reconstructed decimal point per position.
REQ-009 Port digit_valid, output, 4, is 1 per position when that position holds a committed legal hex pattern.
REQ-010 Port pattern_error, output, 4, is 1 per position when the last commit was a non-hex, non-blank pattern.
REQ-011 Port update, output, 1, is a one-cycle pulse when any position's committed value changes.

Function
REQ-012 anodes and segments shall be registered once on entry (stage S1) before any use.
REQ-013 A sample shall be selecting position i only when the S1 anodes equals 4'b1111 with bit i cleared; all other anode values shall be ignored and change no state.
REQ-014 Each position shall keep a candidate (8 bits) and a saturating match counter (4 bits).
REQ-015 On a selecting sample equal to the candidate, the counter shall increment, saturating at STABLE_COUNT.
REQ-016 On a selecting sample that differs from the candidate, the candidate shall load the sample and the counter shall become 1.
REQ-017 A commit shall occur on the cycle the counter first reaches STABLE_COUNT; further matching samples shall not re-commit.
REQ-018 The decode table (pattern to value) shall be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 A commit of a legal pattern shall set the digit, decimal point and digit_valid=1 and clear pattern_error.
REQ-020 A commit of blank (1111111) shall set digit_valid=0 and pattern_error=0, keep the digit unchanged, and still update the decimal point.
REQ-021 A commit of any other pattern shall set digit_valid=0 and pattern_error=1, leaving the digit unchanged.
REQ-022 Outputs shall be registered and change on the clock edge after the commit cycle, giving a total of 2 edges after the edge that registers the STABLE_COUNT-th matching sample into S1.
REQ-023 update shall pulse coincident with the output change when any of the digit, decimal point, digit_valid or pattern_error differs from its previous value for the committing position.
REQ-024 Each position shall have a 16-bit silence counter that clears on any selecting sample for that position and otherwise increments, saturating.
REQ-025 When a silence counter reaches TIMEOUT, digit_valid for that position shall clear and its match counter shall clear, with update pulsing if digit_valid was 1.
REQ-026 If a commit and a timeout fall on the same position in the same cycle, the selection and commit shall win.
REQ-027 Commits on different positions cannot coincide (one-hot select), and timeouts on multiple positions in one cycle shall all apply, producing a single update pulse.

Reset
REQ-028 While reset=1, digits=16'h0000, decimal_points=4'h0, digit_valid=4'h0, pattern_error=4'h0, update=0, all candidates=8'hFF, all match counters=0, all silence counters=0 and S1 registers=all-ones.
REQ-029 Reset asserted mid-accumulation shall discard partial matches, so no commit follows reset release without STABLE_COUNT fresh samples.

Verification
REQ-030 A bench shall drive anodes=1110 and segments=0_0100100 for 4 cycles; digits[3:0]=2, digit_valid[0]=1, and update pulses once, 2 edges after the 4th sample.
REQ-031 A bench shall drive 3 samples of 0010000, then 1 sample of 0000000, then 4 samples of 0000000 on position 2; the only commit is 8, at the 4th 0000000 sample.
REQ-032 A bench shall drive anodes=1100 or 1111 with arbitrary segments for 20 cycles; there are no state changes other than the silence counters.
REQ-033 A bench shall drive pattern 1010101 on position 1 for 4 cycles; pattern_error[1]=1, digit_valid[1]=0, and digits[7:4] unchanged.
REQ-034 A bench shall commit F on position 3 and then leave position 3 unselected for 1024 cycles; digit_valid[3] clears, digits[15:12] stays F, and update pulses once.
REQ-035 A bench shall assert reset after 2 matching samples and then drive 2 more after release; there is no commit, and all outputs stay at their reset values.
